// File: rtl/spi_pkg.sv
// Shared constants, opcodes and state encoding for the SPI master.
// Opcode bit 1 doubles as the slave's read/write select bit.
package spi_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int CMD_W      = 10;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 11;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_GAP
    } mst_state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// TX parallel-load shifter (MSB out first), RX shifter (MSB in first) and phase bit counter.
// Latency: one clk per bit; no backpressure, shifting is driven entirely by the FSM enables.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_dat,
    input  logic                  tx_shift,
    input  logic                  rx_shift,
    input  logic                  cnt_en,
    input  logic                  cnt_clr,
    input  logic                  miso,
    output logic                  mosi_bit,
    output logic [DATA_W-1:0]     rx_next,
    output logic [CNT_W-1:0]      cnt
);

    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]     rx_q, rx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign rx_next  = {rx_q[DATA_W-2:0], miso};
    assign mosi_bit = tx_q[FRAME_BITS-1];
    assign cnt      = cnt_q;

    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        cnt_d = cnt_q;
        if (load) begin
            tx_d = load_dat;
            rx_d = '0;
        end else if (tx_shift) begin
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
        if (rx_shift) begin
            rx_d = rx_next;
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q  <= '0;
            rx_q  <= '0;
            cnt_q <= '0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: accepts one 10-bit command per frame, serialises it MSB-first, captures read data.
// Latency: frame starts the cycle after accept; cmd_ready only in IDLE, commands outside IDLE are dropped.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 2,
    parameter int GAP        = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SS_n
);

    mst_state_t        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              accept;
    logic              mosi_bit;
    logic [DATA_W-1:0] rx_next;
    logic [CNT_W-1:0]  cnt;

    // Gating with rst keeps cmd_ready low during the reset cycle itself.
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SEND;
                    op_d    = cmd_op;
                end
            end
            S_SEND: begin
                if (cnt == CNT_W'(FRAME_BITS - 1)) begin
                    if (op_q != OP_RD_DATA) begin
                        state_d = S_GAP;
                    end else if (TURNAROUND == 0) begin
                        state_d = S_RECV;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(TURNAROUND - 1)) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    state_d     = S_GAP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_next;
                end
            end
            S_GAP: begin
                if (cnt == CNT_W'(GAP - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WR_ADDR;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // The leading bit repeats op[1] so the slave sees its R/W select first.
    spi_master_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_dat ({cmd_op[1], cmd_op, cmd_data}),
        .tx_shift (state_q == S_SEND),
        .rx_shift (state_q == S_RECV),
        .cnt_en   (state_q != S_IDLE),
        .cnt_clr  (state_d != state_q),
        .miso     (MISO),
        .mosi_bit (mosi_bit),
        .rx_next  (rx_next),
        .cnt      (cnt)
    );

    assign SS_n      = !((state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_RECV));
    assign MOSI      = (state_q == S_SEND) && mosi_bit;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a small behavioural slave/RAM model.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       MOSI;
    logic       MISO;
    logic       SS_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl_mem [256];
    logic [7:0] mdl_addr;

    spi_master_ctrl #(.TURNAROUND(2), .GAP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .SS_n      (SS_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame: waits for ready, issues the command, records MOSI bits while SS_n is low,
    // drives miso_byte MSB-first in SS_n-low cycles 13..20, and measures the SS_n-high to ready gap.
    task automatic do_frame(input logic [1:0] op, input logic [7:0] dat, input logic [7:0] miso_byte,
                            output logic [10:0] bits, output int low_cycles, output int vld_cnt,
                            output logic [7:0] rsp, output int gap);
        int n;
        int idx;
        int rise_i;
        int rdy_i;
        cmd_op = op;
        cmd_data = dat;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        cmd_valid = 1'b0;
        cmd_op = ~op;
        cmd_data = ~dat;
        bits = '0;
        low_cycles = 0;
        vld_cnt = 0;
        rsp = 8'h00;
        rise_i = -1;
        rdy_i = -1;
        for (int i = 0; i < 40; i++) begin
            idx = -1;
            if (!SS_n) begin
                if (low_cycles < 11) bits[10-low_cycles] = MOSI;
                idx = low_cycles;
                low_cycles++;
            end else if (low_cycles > 0 && rise_i < 0) begin
                rise_i = i;
            end
            if (rise_i >= 0 && rdy_i < 0 && cmd_ready) rdy_i = i;
            if (rsp_valid) begin
                vld_cnt++;
                rsp = rsp_data;
            end
            MISO = (idx >= 13 && idx <= 20) ? miso_byte[20-idx] : 1'b0;
            tick();
        end
        MISO = 1'b0;
        gap = (rise_i >= 0 && rdy_i >= 0) ? (rdy_i - rise_i) : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        cmd_data = 8'hAA;
        MISO = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n got %b exp 1", SS_n); end
            checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", MOSI); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
        end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
        cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", cmd_ready); end
        tick();
        checks++; if (busy !== 1'b0 || SS_n !== 1'b1) begin
            errors++; $display("FAIL idle_after_reset got busy=%b ss_n=%b exp busy=0 ss_n=1", busy, SS_n);
        end
    endtask

    task automatic test_write_addr();
        logic [10:0] bits;
        int low, vld, gap;
        logic [7:0] rsp;
        do_frame(2'b00, 8'h35, 8'h00, bits, low, vld, rsp, gap);
        checks++; if (bits !== 11'b000_0011_0101) begin errors++; $display("FAIL wr_addr_bits got %b exp 00000110101", bits); end
        checks++; if (low !== 11) begin errors++; $display("FAIL wr_addr_low got %0d exp 11", low); end
        checks++; if (gap !== 1) begin errors++; $display("FAIL wr_addr_gap got %0d exp 1", gap); end
        checks++; if (vld !== 0) begin errors++; $display("FAIL wr_addr_rsp_valid got %0d exp 0", vld); end
    endtask

    task automatic test_read_data();
        logic [10:0] bits;
        int low, vld, gap;
        logic [7:0] rsp;
        do_frame(2'b11, 8'h00, 8'hA5, bits, low, vld, rsp, gap);
        checks++; if (bits !== 11'b111_0000_0000) begin errors++; $display("FAIL rd_data_bits got %b exp 11100000000", bits); end
        checks++; if (low !== 21) begin errors++; $display("FAIL rd_data_low got %0d exp 21", low); end
        checks++; if (vld !== 1) begin errors++; $display("FAIL rd_data_pulses got %0d exp 1", vld); end
        checks++; if (rsp !== 8'hA5) begin errors++; $display("FAIL rd_data_rsp got %h exp a5", rsp); end
        checks++; if (gap !== 1) begin errors++; $display("FAIL rd_data_gap got %0d exp 1", gap); end
        do_frame(2'b01, 8'h77, 8'hFF, bits, low, vld, rsp, gap);
        checks++; if (vld !== 0) begin errors++; $display("FAIL wr_no_rsp got %0d exp 0", vld); end
        checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL rsp_data_hold got %h exp a5", rsp_data); end
    endtask

    task automatic test_back_to_back();
        int n, rise1, fall2, lows;
        logic prev_ss;
        logic [10:0] bits2;
        cmd_op = 2'b01;
        cmd_data = 8'hFF;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        cmd_op = 2'b10;
        cmd_data = 8'h0F;
        prev_ss = SS_n;
        rise1 = -1;
        fall2 = -1;
        lows = 0;
        bits2 = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!prev_ss && SS_n && rise1 < 0) rise1 = cyc;
            if (prev_ss && !SS_n && rise1 >= 0 && fall2 < 0) begin
                fall2 = cyc;
                cmd_valid = 1'b0;
            end
            if (fall2 >= 0 && !SS_n && lows < 11) begin
                bits2[10-lows] = MOSI;
                lows++;
            end
            prev_ss = SS_n;
            tick();
        end
        cmd_valid = 1'b0;
        checks++; if (rise1 !== 11) begin errors++; $display("FAIL b2b_first_len got %0d exp 11", rise1); end
        checks++; if (fall2 - rise1 !== 2) begin errors++; $display("FAIL b2b_gap got %0d exp 2", fall2 - rise1); end
        checks++; if (bits2 !== 11'b110_0000_1111) begin errors++; $display("FAIL b2b_bits got %b exp 11000001111", bits2); end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits;
        int low, vld, gap, n, pulses;
        logic [7:0] rsp;
        cmd_op = 2'b11;
        cmd_data = 8'h00;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (SS_n !== 1'b0) begin errors++; $display("FAIL mid_frame_active got ss_n=%b exp 0", SS_n); end
        rst = 1'b1;
        MISO = 1'b1;
        tick();
        checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL mid_reset_ss_n got %b exp 1", SS_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL mid_reset_rsp_data got %h exp 00", rsp_data); end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) pulses++;
            tick();
        end
        MISO = 1'b0;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_reset_rsp_valid got %0d exp 0", pulses); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL mid_reset_rsp_hold got %h exp 00", rsp_data); end
        do_frame(2'b10, 8'h5C, 8'h00, bits, low, vld, rsp, gap);
        checks++; if (bits !== 11'b110_0101_1100) begin errors++; $display("FAIL post_reset_bits got %b exp 11001011100", bits); end
        checks++; if (low !== 11) begin errors++; $display("FAIL post_reset_low got %0d exp 11", low); end
    endtask

    // The slave model decodes what actually appeared on MOSI, not what the bench asked for.
    task automatic slave_frame(input logic [1:0] op, input logic [7:0] dat, output logic [7:0] rsp, output int vld);
        logic [10:0] bits;
        int low, gap;
        do_frame(op, dat, mdl_mem[mdl_addr], bits, low, vld, rsp, gap);
        case (bits[9:8])
            2'b00: mdl_addr = bits[7:0];
            2'b01: mdl_mem[mdl_addr] = bits[7:0];
            2'b10: mdl_addr = bits[7:0];
            default: ;
        endcase
    endtask

    task automatic test_integration();
        logic [7:0] rsp;
        int vld;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        mdl_addr = 8'h00;
        slave_frame(2'b00, 8'h10, rsp, vld);
        slave_frame(2'b01, 8'h5A, rsp, vld);
        slave_frame(2'b10, 8'h10, rsp, vld);
        slave_frame(2'b11, 8'h00, rsp, vld);
        checks++; if (vld !== 1) begin errors++; $display("FAIL integ_pulses got %0d exp 1", vld); end
        checks++; if (rsp !== 8'h5A) begin errors++; $display("FAIL integ_rsp got %h exp 5a", rsp); end
        checks++; if (rsp_data !== 8'h5A) begin errors++; $display("FAIL integ_rsp_data got %h exp 5a", rsp_data); end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_addr();
        test_read_data();
        test_back_to_back();
        test_reset_mid_frame();
        test_integration();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
